ems_page_mapper: RTL

//  LIM-style EMS page-register block, directly upstream of the SDRAM RAM stage.
//  - Decodes CPU I/O writes into four 8-bit page registers.
//  - Decodes CPU memory addresses against a 64 KB page frame.
//  - Drives map_ems[0:3] and ems_b1..ems_b4, which the RAM stage uses to remap
//    16 KB windows into the 2 MB EMS area.
//  - Provides I/O readback of the page registers.

---
 rtl/ems_page_mapper.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ems_page_mapper.sv
// ems_page_mapper
//   LIM-style EMS page-register block feeding the SDRAM RAM stage.
//   Four 8-bit page registers are written through a small I/O port and
//   remap 16 KB windows of a 64 KB page frame into the 2 MB EMS area.
// Ports
//   clock, reset          system clock, async active-high reset
//   ems_enabled           global enable (decode, writes, readback)
//   ems_address[1:0]      I/O base: 208h/218h/258h/268h
//   ems_frame[1:0]        frame: C0000h/D0000h/E0000h/disabled
//   io_address[15:0]      CPU I/O address
//   internal_data_bus     CPU write data
//   io_read_n/io_write_n  active-low I/O strobes
//   address[19:0]         CPU memory address
//   map_ems[0:3]          page number for each window
//   ems_b1..ems_b4        memory address hits a mapped window
//   io_data_out           page register readback, 0 when not selected
//   io_select_n           low while a page register is being read
module ems_page_mapper #(
  parameter logic [7:0] UNMAPPED_VALUE = 8'hFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ems_enabled,
  input  logic [1:0]       ems_address,
  input  logic [1:0]       ems_frame,
  input  logic [15:0]      io_address,
  input  logic [7:0]       internal_data_bus,
  input  logic             io_read_n,
  input  logic             io_write_n,
  input  logic [19:0]      address,
  output logic [0:3][6:0]  map_ems,
  output logic             ems_b1,
  output logic             ems_b2,
  output logic             ems_b3,
  output logic             ems_b4,
  output logic [7:0]       io_data_out,
  output logic             io_select_n
);

  localparam logic [0:0] WR_IDLE    = 1'b0;
  localparam logic [0:0] WR_CAPTURE = 1'b1;

  logic [3:0][7:0] page_reg;
  logic [0:0]      wr_state;
  logic [1:0]      wr_idx;
  logic [7:0]      wr_data;
  logic [15:0]     base;
  logic            io_hit;
  logic [1:0]      idx;
  logic            frame_hit;
  logic [1:0]      win;
  logic [3:0]      ems_b;

  always_comb begin
    case (ems_address)
      2'd0:    base = 16'h0208;
      2'd1:    base = 16'h0218;
      2'd2:    base = 16'h0258;
      default: base = 16'h0268;
    endcase
  end

  assign io_hit = ems_enabled & (io_address[15:2] == base[15:2]);
  assign idx    = io_address[1:0];

  // Index is latched on the first strobe-low edge only; data keeps following
  // the bus so the commit on the strobe's rising edge uses the last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      wr_idx   <= 2'd0;
      wr_data  <= 8'h00;
      page_reg <= {4{UNMAPPED_VALUE}};
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (io_hit && !io_write_n) begin
            wr_state <= WR_CAPTURE;
            wr_idx   <= idx;
            wr_data  <= internal_data_bus;
          end
        end
        default: begin
          if (!ems_enabled) begin
            wr_state <= WR_IDLE;          // abort, nothing committed
          end else if (!io_write_n) begin
            wr_data  <= internal_data_bus;
          end else begin
            page_reg[wr_idx] <= wr_data;
            wr_state         <= WR_IDLE;
          end
        end
      endcase
    end
  end

  // Readback is combinational, so a simultaneous write shows the old value.
  always_comb begin
    io_select_n = 1'b1;
    io_data_out = 8'h00;
    if (io_hit && !io_read_n) begin
      io_select_n = 1'b0;
      io_data_out = page_reg[idx];
    end
  end

  assign frame_hit = ems_enabled & (ems_frame != 2'd3) &
                     (address[19:16] == (4'hC + {2'b00, ems_frame}));
  assign win = address[15:14];

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_win
      assign map_ems[n] = page_reg[n][6:0];
      // bit7 set means unmapped; the window compare keeps at most one hit
      assign ems_b[n]   = frame_hit & (win == 2'(n)) & ~page_reg[n][7];
    end
  endgenerate

  assign ems_b1 = ems_b[0];
  assign ems_b2 = ems_b[1];
  assign ems_b3 = ems_b[2];
  assign ems_b4 = ems_b[3];

endmodule
